// File: rtl/chirp_if.sv
// Sample stream from the chirp source to the FIR serial input.
// The master drives x_out/x_valid, and the slave returns x_ready.
interface chirp_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] x_out;
  logic                         x_valid;
  logic                         x_ready;

  modport master (output x_out, output x_valid, input x_ready);
  modport slave  (input x_out, input x_valid, output x_ready);
endinterface

// File: rtl/chirp_gen.sv
// Linear-chirp sample source: ramping phase increment, quarter-wave sine ROM, one-entry output register.
// Optional macro CHIRP_LOOP_EN restarts the sweep back-to-back instead of returning to IDLE.
module chirp_gen #(
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = 8,
  parameter int N_SAMPLES      = 1024,
  parameter int FREQ_STEP      = 8192,
  parameter int AMPLITUDE      = 30000,
  localparam int CNT_W         = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  chirp_if.master          xo,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam real HALF_PI = 1.5707963267948966;
  localparam int  LUT_N   = 2 ** LUT_ADDR_WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [PHASE_WIDTH-1:0]       phase_q, phase_d;
  logic [PHASE_WIDTH-1:0]       inc_q, inc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0] x_out_q, x_out_d;
  logic                         x_valid_q, x_valid_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic signed [DATA_WIDTH-1:0] lut_s [LUT_N];
  logic [1:0]                   quad_s;
  logic [LUT_ADDR_WIDTH-1:0]    addr_s, rom_addr_s;
  logic signed [DATA_WIDTH-1:0] rom_val_s, sample_s;
  logic                         transfer_s;

  // Half-step sample points mean no entry is exactly zero.
  for (genvar a = 0; a < LUT_N; a++) begin : g_lut
    localparam real ANGLE = HALF_PI * real'(2 * a + 1) / real'(2 ** (LUT_ADDR_WIDTH + 1));
    localparam int  VAL   = $rtoi(real'(AMPLITUDE) * $sin(ANGLE) + 0.5);
    assign lut_s[a] = DATA_WIDTH'(VAL);
  end

  // Map the current phase to a signed sample.
  always_comb begin
    quad_s     = phase_q[PHASE_WIDTH-1 -: 2];
    addr_s     = phase_q[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    rom_addr_s = quad_s[0] ? ~addr_s : addr_s;
    rom_val_s  = lut_s[rom_addr_s];
    sample_s   = quad_s[1] ? -rom_val_s : rom_val_s;
  end

  assign transfer_s = x_valid_q && xo.x_ready;

  // Next-state logic. Abort overrides start and any transfer.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    inc_d     = inc_q;
    cnt_d     = cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = x_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      phase_d   = {PHASE_WIDTH{1'b0}};
      inc_d     = {PHASE_WIDTH{1'b0}};
      cnt_d     = {CNT_W{1'b0}};
      x_valid_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = RUN;
            phase_d   = {PHASE_WIDTH{1'b0}};
            inc_d     = PHASE_WIDTH'(FREQ_STEP);
            cnt_d     = CNT_W'(1);
            x_out_d   = lut_s[0];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
          end
        end
        RUN: begin
          if (transfer_s && (cnt_q == CNT_W'(N_SAMPLES))) begin
            done_d = 1'b1;
`ifdef CHIRP_LOOP_EN
            phase_d   = {PHASE_WIDTH{1'b0}};
            inc_d     = PHASE_WIDTH'(FREQ_STEP);
            cnt_d     = CNT_W'(1);
            x_out_d   = lut_s[0];
            x_valid_d = 1'b1;
`else
            state_d   = IDLE;
            x_valid_d = 1'b0;
            busy_d    = 1'b0;
`endif
          end else if (transfer_s) begin
            x_out_d = sample_s;
            phase_d = phase_q + inc_q;
            inc_d   = inc_q + PHASE_WIDTH'(FREQ_STEP);
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            x_valid_d = x_valid_q;
          end
        end
        default: begin
          state_d   = IDLE;
          x_valid_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= {PHASE_WIDTH{1'b0}};
      inc_q     <= {PHASE_WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      x_out_q   <= {DATA_WIDTH{1'b0}};
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign xo.x_out   = x_out_q;
  assign xo.x_valid = x_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_chirp_gen.sv
// Directed bench for chirp_gen: vector table for the sweep start and backpressure, plus sequences for the sweep end, abort, reset and quadrants.
module tb_chirp_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [10:0] sample_cnt;
  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic        busy2, done2;
  logic [10:0] sample_cnt2;

  int n_vec = 0;
  int n_err = 0;
  int xfers = 0;

  chirp_if #(.DATA_WIDTH(16)) if1 ();
  chirp_if #(.DATA_WIDTH(16)) if2 ();

  always #5 clk = ~clk;

  chirp_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .xo(if1),
    .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  chirp_gen #(.FREQ_STEP(4194304)) dut_q (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .xo(if2),
    .busy(busy2), .done(done2), .sample_cnt(sample_cnt2)
  );

  typedef struct {
    bit st; bit ab; bit rdy;
    bit ev; int eo; int ec; bit eb;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rdy);
    @(negedge clk);
    start = st; abort = ab; if1.x_ready = rdy;
    if (if1.x_valid && rdy) xfers++;
    @(posedge clk);
    #1;
  endtask

  int exp_q[5];
  int last_out;
  bit got_done;
  int gaps;

  initial begin
    // Sweep start, backpressure after sample 3, start ignored while running.
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0,    0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 92,   1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 92,   2, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 92,   3, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 276,  4, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 276,  4, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 276,  4, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 276,  4, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 276,  4, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 276,  4, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 644,  5, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1012, 6, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1012, 6, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1380, 7, 1'b1};
    exp_q = '{92, 92, 30000, -30000, -92};

    if1.x_ready = 1'b0;
    if2.x_ready = 1'b1;
    #22;
    chk("reset_valid", int'(if1.x_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_out", int'(if1.x_out), 0);
    chk("reset_cnt", int'(sample_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].st, tbl[i].ab, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(if1.x_valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_out", i), int'(if1.x_out), tbl[i].eo);
      chk($sformatf("tbl%0d_cnt", i), int'(sample_cnt), tbl[i].ec);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
    end

    // Run to the end of the sweep under continuous ready.
    got_done = 1'b0;
    gaps = 0;
    last_out = 0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      if (if1.x_valid && sample_cnt == 11'd1024) last_out = int'(if1.x_out);
      step(1'b0, 1'b0, 1'b1);
      if (done) got_done = 1'b1;
      else if (!if1.x_valid) gaps++;
    end
    chk("done_seen", int'(got_done), 1);
    chk("valid_gaps", gaps, 0);
    chk("total_xfers", xfers, 1024);
    chk("last_sample", last_out, 30000);
`ifdef CHIRP_LOOP_EN
    chk("loop_valid", int'(if1.x_valid), 1);
    chk("loop_busy", int'(busy), 1);
    chk("loop_s0", int'(if1.x_out), 92);
    chk("loop_cnt", int'(sample_cnt), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("loop_done_off", int'(done), 0);
    chk("loop_s1", int'(if1.x_out), 92);
    chk("loop_valid2", int'(if1.x_valid), 1);
`else
    chk("end_valid", int'(if1.x_valid), 0);
    chk("end_busy", int'(busy), 0);
    chk("end_cnt", int'(sample_cnt), 1024);
    step(1'b0, 1'b0, 1'b1);
    chk("done_off", int'(done), 0);
    chk("idle_cnt_hold", int'(sample_cnt), 1024);
`endif

    // Abort at sample_cnt 500, then restart.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 1000 && sample_cnt != 11'd500; c++) step(1'b0, 1'b0, 1'b1);
    chk("reach_500", int'(sample_cnt), 500);
    step(1'b0, 1'b1, 1'b1);
    chk("abort_valid", int'(if1.x_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cnt", int'(sample_cnt), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("abort_no_done", int'(done), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("start_abort_valid", int'(if1.x_valid), 0);
    chk("start_abort_busy", int'(busy), 0);
    step(1'b1, 1'b0, 1'b1);
    chk("restart_s0", int'(if1.x_out), 92);
    chk("restart_cnt", int'(sample_cnt), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("restart_s1", int'(if1.x_out), 92);

    // Quadrant mapping with a quarter-circle increment step.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("quad_s%0d", k), int'(if2.x_out), exp_q[k]);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-sweep, no clock edge needed.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(if1.x_valid), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_out", int'(if1.x_out), 0);
    chk("rst_mid_cnt", int'(sample_cnt), 0);
    chk("rst_mid_busy2", int'(busy2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chirp_gen.md
Name: chirp_gen

Overview:
- Hardware linear-chirp sample source that drives the serial FIR input interface (x_in/x_valid) in place of a bench stimulus.
- Phase accumulator with linearly ramping increment, quarter-wave sine ROM, and a one-entry output register with valid/ready handshake.
- Used for on-chip frequency-response sweeps, 0 to Nyquist, of the FIR.

Parameters:
DATA_WIDTH, 16, signed output sample width
PHASE_WIDTH, 24, phase accumulator and increment width; full circle = 2^PHASE_WIDTH
LUT_ADDR_WIDTH, 8, quarter-wave ROM address width (256 entries); must be <= PHASE_WIDTH-2
N_SAMPLES, 1024, samples per sweep
FREQ_STEP, 8192, increment ramp per sample; default 2^(PHASE_WIDTH-1)/N_SAMPLES reaches Nyquist at sweep end
AMPLITUDE, 30000, peak magnitude; must be < 2^(DATA_WIDTH-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a sweep; ignored unless IDLE
abort  in  1  terminate the sweep; return to IDLE next edge
x_out  out  DATA_WIDTH  signed sample, connects to FIR x_in
x_valid  out  1  x_out holds a valid sample
x_ready  in  1  consumer accepts; transfer = x_valid && x_ready at a rising edge
busy  out  1  high while in RUN
done  out  1  one-cycle pulse after the final sample transfers
sample_cnt  out  $clog2(N_SAMPLES+1)  number of samples loaded so far in the current sweep

Behaviour:
- Reset (async, rst_n=0): state=IDLE; phase=0, inc=0, sample_cnt=0, x_out=0, x_valid=0, busy=0, done=0.
- ROM: LUT[a] = round(AMPLITUDE*sin(pi/2*(2a+1)/2^(LUT_ADDR_WIDTH+1))). Computed at elaboration. Half-step offset, so there is no exact zero.
- Lookup: q = phase[PW-1:PW-2], a = phase[PW-3 -: LUT_ADDR_WIDTH] (truncate).
  - q0 -> LUT[a]
  - q1 -> LUT[~a]
  - q2 -> -LUT[a]
  - q3 -> -LUT[~a]
  - The lookup is combinational from the current phase.
- Sample k: phase_k = sum of inc_j for j<k. inc_k = k*FREQ_STEP. Both wrap mod 2^PHASE_WIDTH.
- IDLE: x_valid=0, busy=0.
  - On start, at the same edge: x_out<=sample 0, x_valid<=1, sample_cnt<=1, phase<=phase_0+inc_0, inc<=FREQ_STEP, state<=RUN.
  - Start-to-first-valid latency is 1 cycle.
- RUN: busy=1.
  - On a transfer with sample_cnt<N_SAMPLES: load the next sample, advance phase (phase+=inc, inc+=FREQ_STEP), and increment sample_cnt. This gives back-to-back samples under continuous x_ready.
  - On a transfer with sample_cnt==N_SAMPLES: x_valid<=0, done<=1 for one cycle, state<=IDLE.
  - Without a transfer, x_out, x_valid, phase, inc and sample_cnt hold. x_out must be stable while x_valid && !x_ready.
- abort (any state, priority over start and transfer): next edge x_valid<=0, busy<=0, state<=IDLE, phase/inc/sample_cnt<=0, no done pulse.
- start while RUN: ignored. start and abort in the same cycle: abort wins.
- sample_cnt holds its final value in IDLE until the next start or abort.
- Reset asserted mid-sweep: immediate return to reset values. The partial sweep is lost.

Optional Feature:
- Macro CHIRP_LOOP_EN.
- Defined: after the final transfer, done pulses and the sweep restarts without idle cycles. The next edge loads sample 0 of a new sweep with x_valid held high. busy stays 1, and abort is the only exit.
- Undefined: single sweep, return to IDLE as above.

Test Plan:
1. Reset: rst_n=0 mid-RUN -> x_valid=0, busy=0, x_out=0, sample_cnt=0 with no clock edge required.
2. Default params, start, x_ready=1 -> x_out=92 on the first two samples (phase 0). Exactly 1024 x_valid cycles back-to-back. done high for 1 cycle after the last transfer. busy then 0.
3. FREQ_STEP=4194304 -> samples 0..4 = 92, 92, 30000, -30000, -92, confirming all four quadrant mappings.
4. Backpressure: x_ready low for 5 cycles after sample 3 -> x_out and sample_cnt hold. Sample 4 appears the cycle after x_ready returns. Total transfers still 1024.
5. abort at sample_cnt=500 -> x_valid=0 next cycle, no done. A new start yields sample 0 = 92 again.
6. CHIRP_LOOP_EN defined -> done pulses every 1024 transfers, x_valid stays continuously high across the boundary, and the sample after the boundary = 92.
